// File: rtl/prim_fault_inject_pkg.sv
// Shared types for the fault-injecting single-port RAM: slot layout, fault modes
// and the per-slot mask application used on the read path.
package prim_fault_inject_pkg;

  localparam int MaxWidth = 128;
  localparam int MaxAw    = 32;

  typedef enum logic [1:0] {
    FaultOff    = 2'd0,
    FaultFlip   = 2'd1,
    FaultStuck0 = 2'd2,
    FaultStuck1 = 2'd3
  } fault_mode_e;

  typedef struct packed {
    logic [MaxAw-1:0]    addr;
    logic [MaxWidth-1:0] mask;
    fault_mode_e         mode;
    logic                oneshot;
  } fault_slot_t;

  typedef struct packed {
    logic       cfg_en;
    logic [3:0] cfg;
  } ram_1p_cfg_t;

  function automatic logic [MaxWidth-1:0] apply_fault(input logic [MaxWidth-1:0] data,
                                                      input logic [MaxWidth-1:0] mask,
                                                      input fault_mode_e         mode);
    logic [MaxWidth-1:0] res;
    res = data;
    case (mode)
      FaultFlip:   res = data ^ mask;
      FaultStuck0: res = data & ~mask;
      FaultStuck1: res = data | mask;
      default:     res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/prim_generic_ram_1p.sv
// Generic single-port RAM: registered read, bit-group write mask, no reset on contents.
module prim_generic_ram_1p
  import prim_fault_inject_pkg::*;
#(
  parameter int    Width           = 32,
  parameter int    Depth           = 128,
  parameter int    DataBitsPerMask = 1,
  parameter string MemInitFile     = "",
  localparam int   Aw              = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             req_i,
  input  logic             write_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic [Width-1:0] rdata_o,
  input  ram_1p_cfg_t      cfg_i
);

  localparam int MaskWidth = Width / DataBitsPerMask;

  // Preloading is left to the memory-compiler flow for this generic model.
  localparam bit unused_init = (MemInitFile != "");

  logic unused_cfg;
  assign unused_cfg = ^cfg_i;

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (write_i) begin
        for (int unsigned k = 0; k < MaskWidth; k++) begin
          if (wmask_i[k*DataBitsPerMask]) begin
            mem[addr_i][k*DataBitsPerMask +: DataBitsPerMask] <=
              wdata_i[k*DataBitsPerMask +: DataBitsPerMask];
          end
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/prim_fault_inject_ram_1p.sv
// Single-port RAM with programmable fault slots corrupting read data (flip/stuck),
// optional one-shot slots, a read-valid strobe and a saturating corrupted-read count.
module prim_fault_inject_ram_1p
  import prim_fault_inject_pkg::*;
#(
  parameter int    Width           = 32,
  parameter int    Depth           = 128,
  parameter int    DataBitsPerMask = 1,
  parameter string MemInitFile     = "",
  parameter int    NumFaults       = 4,
  parameter int    CntW            = 16,
  localparam int   Aw              = $clog2(Depth),
  localparam int   Iw              = (NumFaults > 1) ? $clog2(NumFaults) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             write_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic [Width-1:0] rdata_o,
  output logic             rvalid_o,
  input  logic             inject_en_i,
  input  logic             fault_we_i,
  input  logic [Iw-1:0]    fault_idx_i,
  input  logic [Aw-1:0]    fault_addr_i,
  input  logic [Width-1:0] fault_mask_i,
  input  logic [1:0]       fault_mode_i,
  input  logic             fault_oneshot_i,
  output logic [CntW-1:0]  fault_hit_cnt_o,
  output logic             fault_hit_o
);

  logic [Width-1:0] sram_rdata;

  prim_generic_ram_1p #(
    .Width           (Width),
    .Depth           (Depth),
    .DataBitsPerMask (DataBitsPerMask),
    .MemInitFile     (MemInitFile)
  ) u_ram (
    .clk_i   (clk_i),
    .req_i   (req_i),
    .write_i (write_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .wmask_i (wmask_i),
    .rdata_o (sram_rdata),
    .cfg_i   ('0)
  );

  fault_slot_t           slots_q [NumFaults];
  fault_slot_t           new_slot;
  logic                  read_req;
  logic                  idx_ok;
  logic [NumFaults-1:0]  hit_d;
  logic [NumFaults-1:0]  hits_q;
  logic                  rvalid_q;
  logic [CntW-1:0]       cnt_q;
  logic [MaxWidth-1:0]   app_mask_q [NumFaults];
  fault_mode_e           app_mode_q [NumFaults];
  logic [MaxWidth-1:0]   rdata_full;

  assign read_req = req_i & ~write_i;
  assign idx_ok   = ({1'b0, fault_idx_i} < (Iw+1)'(NumFaults));

  always_comb begin
    new_slot         = '0;
    new_slot.addr    = MaxAw'(fault_addr_i);
    new_slot.mask    = MaxWidth'(fault_mask_i);
    new_slot.mode    = fault_mode_e'(fault_mode_i);
    new_slot.oneshot = fault_oneshot_i;
  end

  always_comb begin
    hit_d = '0;
    for (int unsigned i = 0; i < NumFaults; i++) begin
      hit_d[i] = read_req & inject_en_i & (slots_q[i].mode != FaultOff) &
                 (slots_q[i].addr == MaxAw'(addr_i));
    end
  end

  // A programming write to a slot overrides that slot's own one-shot clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumFaults; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumFaults; i++) begin
        if (fault_we_i && idx_ok && (fault_idx_i == Iw'(i))) begin
          slots_q[i] <= new_slot;
        end else if (hit_d[i] && slots_q[i].oneshot) begin
          slots_q[i].mode <= FaultOff;
        end
      end
    end
  end

  // Mask/mode are snapshotted with the request so a one-shot clear or a
  // reprogram in the request cycle cannot alter the data returned next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      hits_q   <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < NumFaults; i++) begin
        app_mask_q[i] <= '0;
        app_mode_q[i] <= FaultOff;
      end
    end else begin
      rvalid_q <= read_req;
      hits_q   <= hit_d;
      if ((|hit_d) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (read_req) begin
        for (int unsigned i = 0; i < NumFaults; i++) begin
          app_mask_q[i] <= slots_q[i].mask;
          app_mode_q[i] <= slots_q[i].mode;
        end
      end
    end
  end

  always_comb begin
    rdata_full = MaxWidth'(sram_rdata);
    for (int unsigned i = 0; i < NumFaults; i++) begin
      if (hits_q[i]) begin
        rdata_full = apply_fault(rdata_full, app_mask_q[i], app_mode_q[i]);
      end
    end
  end

  if (Width < MaxWidth) begin : gen_unused_hi
    logic unused_hi;
    assign unused_hi = ^rdata_full[MaxWidth-1:Width];
  end

  assign rdata_o         = rdata_full[Width-1:0];
  assign rvalid_o        = rvalid_q;
  assign fault_hit_o     = rvalid_q & (|hits_q);
  assign fault_hit_cnt_o = cnt_q;

endmodule

// File: tb/tb_prim_fault_inject_ram_1p.sv
// Bench for prim_fault_inject_ram_1p: directed vector table, hand sequences for
// slot-index bounds, saturation and mid-request reset, then randomized traffic.
module tb_prim_fault_inject_ram_1p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req, wr, inj, fwe, fone;
  logic [6:0]  addr, faddr;
  logic [31:0] wdata, wmask, fmask;
  logic [1:0]  fidx, fmode;

  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, hit_a, hit_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int total = 0;
  int bad = 0;

  prim_fault_inject_ram_1p #(
    .Width(32), .Depth(128), .DataBitsPerMask(1), .MemInitFile(""), .NumFaults(4), .CntW(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .write_i(wr), .addr_i(addr),
    .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata_a), .rvalid_o(rvalid_a),
    .inject_en_i(inj), .fault_we_i(fwe), .fault_idx_i(fidx), .fault_addr_i(faddr),
    .fault_mask_i(fmask), .fault_mode_i(fmode), .fault_oneshot_i(fone),
    .fault_hit_cnt_o(cnt_a), .fault_hit_o(hit_a)
  );

  // Narrow instance: 3 slots (index 3 out of range) and a 2-bit counter.
  prim_fault_inject_ram_1p #(
    .Width(32), .Depth(128), .DataBitsPerMask(1), .MemInitFile(""), .NumFaults(3), .CntW(2)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .write_i(wr), .addr_i(addr),
    .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata_b), .rvalid_o(rvalid_b),
    .inject_en_i(inj), .fault_we_i(fwe), .fault_idx_i(fidx), .fault_addr_i(faddr),
    .fault_mask_i(fmask), .fault_mode_i(fmode), .fault_oneshot_i(fone),
    .fault_hit_cnt_o(cnt_b), .fault_hit_o(hit_b)
  );

  // Reference model: memory image plus per-instance slot tables.
  logic [31:0] mem_m [128];
  logic [6:0]  ms_addr [2][4];
  logic [31:0] ms_mask [2][4];
  logic [1:0]  ms_mode [2][4];
  logic        ms_one  [2][4];
  int unsigned cnt_m [2];
  int          numf [2] = '{4, 3};
  int unsigned cmax [2] = '{65535, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt_m[k] = 0;
      for (int i = 0; i < 4; i++) begin
        ms_addr[k][i] = '0; ms_mask[k][i] = '0; ms_mode[k][i] = '0; ms_one[k][i] = 1'b0;
      end
    end
  endtask

  task automatic idle();
    req = 0; wr = 0; addr = '0; wdata = '0; wmask = '0; inj = 0;
    fwe = 0; fidx = '0; faddr = '0; fmask = '0; fmode = '0; fone = 0;
  endtask

  // Applies the current inputs for one clock, predicting both instances.
  task automatic step();
    logic [31:0] e_data [2];
    logic        e_hit [2];
    logic        rd;
    logic [31:0] d;
    logic        any;
    logic [31:0] rdv;
    logic        rvv, htv;
    logic [31:0] ctv;
    rd = req && !wr;
    for (int k = 0; k < 2; k++) begin
      d = mem_m[addr];
      any = 1'b0;
      for (int i = 0; i < numf[k]; i++) begin
        if (rd && inj && ms_mode[k][i] != 2'd0 && ms_addr[k][i] == addr) begin
          any = 1'b1;
          case (ms_mode[k][i])
            2'd1: d = d ^ ms_mask[k][i];
            2'd2: d = d & ~ms_mask[k][i];
            default: d = d | ms_mask[k][i];
          endcase
          if (ms_one[k][i]) ms_mode[k][i] = 2'd0;
        end
      end
      e_data[k] = d;
      e_hit[k] = any;
      if (any && cnt_m[k] < cmax[k]) cnt_m[k]++;
      if (fwe && int'(fidx) < numf[k]) begin
        ms_addr[k][fidx] = faddr; ms_mask[k][fidx] = fmask;
        ms_mode[k][fidx] = fmode; ms_one[k][fidx] = fone;
      end
    end
    if (req && wr) mem_m[addr] = (mem_m[addr] & ~wmask) | (wdata & wmask);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      rvv = (k == 0) ? rvalid_a : rvalid_b;
      rdv = (k == 0) ? rdata_a : rdata_b;
      htv = (k == 0) ? hit_a : hit_b;
      ctv = (k == 0) ? 32'(cnt_a) : 32'(cnt_b);
      check($sformatf("model%0d rvalid", k), 32'(rvv), 32'(rd));
      if (rd) check($sformatf("model%0d rdata", k), rdv, e_data[k]);
      check($sformatf("model%0d hit", k), 32'(htv), 32'(e_hit[k]));
      check($sformatf("model%0d cnt", k), ctv, 32'(cnt_m[k]));
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        req, wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        inj, fwe;
    logic [1:0]  fidx;
    logic [6:0]  faddr;
    logic [31:0] fmask;
    logic [1:0]  fmode;
    logic        fone;
    logic        ev;
    logic [31:0] edata;
    logic        ehit;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v_wr(input logic [6:0] a, input logic [31:0] d, input logic [15:0] ec);
    vec_t v;
    v = '{req:1, wr:1, addr:a, wdata:d, inj:1, fwe:0, fidx:0, faddr:0, fmask:0, fmode:0,
          fone:0, ev:0, edata:0, ehit:0, ecnt:ec};
    return v;
  endfunction

  function automatic vec_t v_rd(input logic [6:0] a, input logic i, input logic [31:0] ed,
                                input logic eh, input logic [15:0] ec);
    vec_t v;
    v = '{req:1, wr:0, addr:a, wdata:0, inj:i, fwe:0, fidx:0, faddr:0, fmask:0, fmode:0,
          fone:0, ev:1, edata:ed, ehit:eh, ecnt:ec};
    return v;
  endfunction

  function automatic vec_t v_pg(input logic [1:0] ix, input logic [6:0] fa, input logic [31:0] m,
                                input logic [1:0] md, input logic o, input logic [15:0] ec);
    vec_t v;
    v = '{req:0, wr:0, addr:0, wdata:0, inj:1, fwe:1, fidx:ix, faddr:fa, fmask:m, fmode:md,
          fone:o, ev:0, edata:0, ehit:0, ecnt:ec};
    return v;
  endfunction

  function automatic vec_t v_rdpg(input logic [6:0] a, input logic [31:0] ed, input logic eh,
                                  input logic [15:0] ec, input logic [1:0] ix, input logic [6:0] fa,
                                  input logic [31:0] m, input logic [1:0] md, input logic o);
    vec_t v;
    v = v_rd(a, 1'b1, ed, eh, ec);
    v.fwe = 1; v.fidx = ix; v.faddr = fa; v.fmask = m; v.fmode = md; v.fone = o;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int n);
    req = v.req; wr = v.wr; addr = v.addr; wdata = v.wdata; wmask = '1; inj = v.inj;
    fwe = v.fwe; fidx = v.fidx; faddr = v.faddr; fmask = v.fmask; fmode = v.fmode; fone = v.fone;
    step();
    check($sformatf("row%0d rvalid", n), 32'(rvalid_a), 32'(v.ev));
    if (v.ev) begin
      check($sformatf("row%0d rdata", n), rdata_a, v.edata);
      check($sformatf("row%0d hit", n), 32'(hit_a), 32'(v.ehit));
    end
    check($sformatf("row%0d cnt", n), 32'(cnt_a), 32'(v.ecnt));
  endtask

  initial begin
    idle();
    model_reset();
    repeat (3) @(negedge clk);
    check("reset rvalid_a", 32'(rvalid_a), 0);
    check("reset hit_a", 32'(hit_a), 0);
    check("reset cnt_a", 32'(cnt_a), 0);
    check("reset rvalid_b", 32'(rvalid_b), 0);
    check("reset hit_b", 32'(hit_b), 0);
    check("reset cnt_b", 32'(cnt_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 128; a++) begin
      idle(); req = 1; wr = 1; addr = 7'(a); wdata = $urandom; wmask = '1;
      step();
    end

    vq.push_back(v_wr(7'd5, 32'hDEADBEEF, 16'd0));
    vq.push_back(v_wr(7'd6, 32'h12345678, 16'd0));
    vq.push_back(v_wr(7'd7, 32'h00000000, 16'd0));
    vq.push_back(v_rd(7'd5, 1, 32'hDEADBEEF, 0, 16'd0));
    vq.push_back(v_pg(2'd0, 7'd5, 32'h0000000F, 2'd1, 0, 16'd0));
    vq.push_back(v_rd(7'd5, 1, 32'hDEADBEE0, 1, 16'd1));
    vq.push_back(v_rd(7'd5, 1, 32'hDEADBEE0, 1, 16'd2));
    vq.push_back(v_rd(7'd6, 1, 32'h12345678, 0, 16'd2));
    vq.push_back(v_pg(2'd1, 7'd5, 32'hFF000000, 2'd3, 0, 16'd2));
    vq.push_back(v_pg(2'd2, 7'd5, 32'h0F000000, 2'd2, 0, 16'd2));
    vq.push_back(v_pg(2'd0, 7'd5, 32'h00000000, 2'd0, 0, 16'd2));
    vq.push_back(v_rd(7'd5, 1, 32'hF0ADBEEF, 1, 16'd3));
    vq.push_back(v_pg(2'd0, 7'd5, 32'hFF000000, 2'd1, 0, 16'd3));
    vq.push_back(v_rd(7'd5, 1, 32'hF0ADBEEF, 1, 16'd4));
    vq.push_back(v_pg(2'd3, 7'd7, 32'h00000001, 2'd1, 1, 16'd4));
    vq.push_back(v_rd(7'd7, 1, 32'h00000001, 1, 16'd5));
    vq.push_back(v_rd(7'd7, 1, 32'h00000000, 0, 16'd5));
    vq.push_back(v_rdpg(7'd5, 32'hF0ADBEEF, 1, 16'd6, 2'd1, 7'd5, 32'h0, 2'd0, 0));
    vq.push_back(v_rd(7'd5, 1, 32'h20ADBEEF, 1, 16'd7));
    vq.push_back(v_rd(7'd5, 0, 32'hDEADBEEF, 0, 16'd7));
    vq.push_back(v_pg(2'd3, 7'd7, 32'h00000001, 2'd1, 1, 16'd7));
    vq.push_back(v_rdpg(7'd7, 32'h00000001, 1, 16'd8, 2'd3, 7'd7, 32'h00000002, 2'd1, 0));
    vq.push_back(v_rd(7'd7, 1, 32'h00000002, 1, 16'd9));
    vq.push_back(v_rd(7'd7, 1, 32'h00000002, 1, 16'd10));
    foreach (vq[n]) apply_vec(vq[n], n);

    // Slot index 3 exists only on the 4-slot instance.
    idle(); fwe = 1; fidx = 2'd3; faddr = 7'd6; fmask = '1; fmode = 2'd1;
    step();
    idle(); req = 1; addr = 7'd6; inj = 1;
    step();
    check("idx3 rdata_a", rdata_a, 32'hEDCBA987);
    check("idx3 rdata_b", rdata_b, 32'h12345678);
    check("idx3 hit_b", 32'(hit_b), 0);

    check("sat cnt_b start", 32'(cnt_b), 3);
    for (int r = 0; r < 3; r++) begin
      idle(); req = 1; addr = 7'd5; inj = 1;
      step();
      check("sat hit_b", 32'(hit_b), 1);
      check("sat cnt_b", 32'(cnt_b), 3);
    end

    idle(); req = 1; addr = 7'd5; inj = 1;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst rvalid_a", 32'(rvalid_a), 0);
    check("midrst rvalid_b", 32'(rvalid_b), 0);
    check("midrst hit_a", 32'(hit_a), 0);
    check("midrst cnt_a", 32'(cnt_a), 0);
    check("midrst cnt_b", 32'(cnt_b), 0);
    @(negedge clk);
    idle(); rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("postrst rvalid_a", 32'(rvalid_a), 0);
    @(negedge clk);
    idle(); req = 1; addr = 7'd5; inj = 1;
    step();
    check("postrst rdata_a", rdata_a, 32'hDEADBEEF);
    check("postrst hit_a", 32'(hit_a), 0);

    for (int c = 0; c < 800; c++) begin
      int unsigned r;
      idle();
      r = $urandom_range(0, 9);
      inj = ($urandom_range(0, 7) != 0);
      addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'(5 + $urandom_range(0, 2));
      if (r < 6) begin
        req = 1;
      end else if (r < 7) begin
        req = 1; wr = 1; wdata = $urandom; wmask = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        fwe = 1; fidx = 2'($urandom);
        faddr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'(5 + $urandom_range(0, 2));
        fmask = $urandom; fmode = 2'($urandom); fone = 1'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
